// File: rtl/pacman_audio_pkg.sv
// Shared constants for the Pac-Man sound-effect streamer: clip table, register map, FSM states.
package pacman_audio_pkg;

  localparam int unsigned CLIP_COUNT = 4;

  // Clip order: chomp, death, siren, eat_ghost (eat_ghost not yet authored, length 0)
  localparam int unsigned CLIP_START [CLIP_COUNT] = '{100, 103, 200, 0};
  localparam int unsigned CLIP_LEN   [CLIP_COUNT] = '{3, 3, 2, 0};

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_VOLUME = 3'd1;

  localparam int unsigned CTRL_START    = 0;
  localparam int unsigned CTRL_CLIP_LSB = 1;
  localparam int unsigned CTRL_LOOP     = 3;
  localparam int unsigned CTRL_STOP     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWaitTick,
    StFetch,
    StLoad
  } state_e;

endpackage

// File: rtl/audio_rate_tick.sv
// Sample-period divider: counts 0..DIV-1 while enabled and pulses tick on the last count.
module audio_rate_tick #(
  parameter int unsigned DIV = 1042
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic enable,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] cnt_q;

  assign tick = enable && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LAST;
    end else if (enable) begin
      cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/pacman_audio_streamer.sv
// Streams clip samples from the sample ROM to the codec L/R ready/valid channels.
// Optional volume shifter enabled by defining PACMAN_AUDIO_VOLUME_EN.
module pacman_audio_streamer
  import pacman_audio_pkg::*;
#(
  parameter int unsigned DIV       = 1042,
  parameter int unsigned ADDR_W    = 15,
  parameter int unsigned NUM_CLIPS = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              chipselect,
  input  logic              write,
  input  logic [2:0]        address,
  input  logic [15:0]       writedata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_rddata,
  input  logic              L_READY,
  input  logic              R_READY,
  output logic [15:0]       L_DATA,
  output logic [15:0]       R_DATA,
  output logic              L_VALID,
  output logic              R_VALID,
  output logic              playing,
  output logic [7:0]        overrun_count
);

  state_e            state_q;
  logic [ADDR_W-1:0] start_q, len_q, index_q;
  logic              loop_q;
  logic              tick;
  logic [15:0]       sample;

  logic       ctrl_wr, stop_cmd, start_cmd, clip_ok, overrun;
  logic [1:0] clip_sel;

  assign ctrl_wr   = chipselect && write && (address == REG_CTRL);
  assign clip_sel  = writedata[CTRL_CLIP_LSB +: 2];
  assign clip_ok   = (32'(clip_sel) < NUM_CLIPS) && (CLIP_LEN[clip_sel] != 0);
  assign stop_cmd  = ctrl_wr && writedata[CTRL_STOP];
  assign start_cmd = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_STOP] && clip_ok;
  assign overrun   = (L_VALID && !L_READY) || (R_VALID && !R_READY);

  logic unused_wdata;
  assign unused_wdata = ^writedata[15:5];

`ifdef PACMAN_AUDIO_VOLUME_EN
  logic [2:0] volume_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      volume_q <= '0;
    end else if (chipselect && write && (address == REG_VOLUME)) begin
      volume_q <= writedata[2:0];
    end
  end

  assign sample = $signed(rom_rddata) >>> volume_q;
`else
  assign sample = rom_rddata;
`endif

  audio_rate_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (start_cmd),
    .enable (state_q != StIdle),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      start_q       <= '0;
      len_q         <= '0;
      index_q       <= '0;
      loop_q        <= 1'b0;
      rom_addr      <= '0;
      L_DATA        <= '0;
      R_DATA        <= '0;
      L_VALID       <= 1'b0;
      R_VALID       <= 1'b0;
      playing       <= 1'b0;
      overrun_count <= '0;
    end else begin
      if (L_VALID && L_READY) L_VALID <= 1'b0;
      if (R_VALID && R_READY) R_VALID <= 1'b0;

      // Commands preempt the FSM so an in-flight fetch/load is dropped
      if (stop_cmd) begin
        state_q <= StIdle;
        playing <= 1'b0;
      end else if (start_cmd) begin
        start_q <= ADDR_W'(CLIP_START[clip_sel]);
        len_q   <= ADDR_W'(CLIP_LEN[clip_sel]);
        loop_q  <= writedata[CTRL_LOOP];
        index_q <= '0;
        state_q <= StWaitTick;
        playing <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: ;
          StWaitTick: begin
            if (tick) begin
              rom_addr <= start_q + index_q;
              state_q  <= StFetch;
            end
          end
          StFetch: state_q <= StLoad;
          StLoad: begin
            L_DATA  <= sample;
            R_DATA  <= sample;
            L_VALID <= 1'b1;
            R_VALID <= 1'b1;
            if (overrun && (overrun_count != 8'hFF)) overrun_count <= overrun_count + 8'd1;
            if (index_q == len_q - 1'b1) begin
              index_q <= '0;
              if (loop_q) begin
                state_q <= StWaitTick;
              end else begin
                state_q <= StIdle;
                playing <= 1'b0;
              end
            end else begin
              index_q <= index_q + 1'b1;
              state_q <= StWaitTick;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pacman_audio_streamer.sv
// Directed self-checking bench for pacman_audio_streamer with DIV=8.
module tb_pacman_audio_streamer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  address = '0;
  logic [15:0] writedata = '0;
  logic [14:0] rom_addr;
  logic [15:0] rom_rddata = '0;
  logic        L_READY = 1'b0;
  logic        R_READY = 1'b0;
  logic [15:0] L_DATA, R_DATA;
  logic        L_VALID, R_VALID, playing;
  logic [7:0]  overrun_count;
  logic        force_8000 = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  pacman_audio_streamer #(
    .DIV      (8),
    .ADDR_W   (15),
    .NUM_CLIPS(4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .chipselect   (chipselect),
    .write        (write),
    .address      (address),
    .writedata    (writedata),
    .rom_addr     (rom_addr),
    .rom_rddata   (rom_rddata),
    .L_READY      (L_READY),
    .R_READY      (R_READY),
    .L_DATA       (L_DATA),
    .R_DATA       (R_DATA),
    .L_VALID      (L_VALID),
    .R_VALID      (R_VALID),
    .playing      (playing),
    .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [14:0] a);
    return 16'h1000 + {1'b0, a};
  endfunction

  // One-cycle-latency sample ROM
  always @(posedge clk) rom_rddata <= force_8000 ? 16'h8000 : rom_word(rom_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    step(1);
    chipselect = 1'b0;
    write      = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_rom_addr", 32'(rom_addr), 0);
    check("rst_valid", {30'b0, L_VALID, R_VALID}, 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_overrun", 32'(overrun_count), 0);
    check("rst_ldata", 32'(L_DATA), 0);
    reset_n = 1'b1;
    step(2);

    // Single-shot clip 0, READY held high
    L_READY = 1'b1;
    R_READY = 1'b1;
    write_reg(3'd0, 16'h0001);
    check("one_playing", 32'(playing), 1);
    step(1);
    check("one_addr0", 32'(rom_addr), 100);
    step(2);
    check("one_lvalid0", 32'(L_VALID), 1);
    check("one_ldata0", 32'(L_DATA), 32'(rom_word(15'd100)));
    step(1);
    check("one_lvalid_drop", 32'(L_VALID), 0);
    step(5);
    check("one_addr1", 32'(rom_addr), 101);
    step(8);
    check("one_addr2", 32'(rom_addr), 102);
    step(1);
    check("one_playing_last", 32'(playing), 1);
    step(1);
    check("one_rvalid2", 32'(R_VALID), 1);
    check("one_rdata2", 32'(R_DATA), 32'(rom_word(15'd102)));
    check("one_playing_end", 32'(playing), 0);
    step(3);

    // Looping clip 0, then STOP mid-fetch
    write_reg(3'd0, 16'h0009);
    step(1);
    check("loop_addr0", 32'(rom_addr), 100);
    step(8);
    check("loop_addr1", 32'(rom_addr), 101);
    step(8);
    check("loop_addr2", 32'(rom_addr), 102);
    step(8);
    check("loop_wrap", 32'(rom_addr), 100);
    step(8);
    check("loop_addr4", 32'(rom_addr), 101);
    check("loop_playing", 32'(playing), 1);
    write_reg(3'd0, 16'h0010);
    check("stop_playing", 32'(playing), 0);
    step(2);
    check("stop_no_valid", {30'b0, L_VALID, R_VALID}, 0);
    check("stop_addr_hold", 32'(rom_addr), 101);

    // Overrun: READY low for the whole clip
    L_READY = 1'b0;
    R_READY = 1'b0;
    write_reg(3'd0, 16'h0001);
    step(12);
    check("ovr_hold_data", 32'(L_DATA), 32'(rom_word(15'd101)));
    step(7);
    check("ovr_valid", {30'b0, L_VALID, R_VALID}, 3);
    check("ovr_ldata", 32'(L_DATA), 32'(rom_word(15'd102)));
    check("ovr_count", 32'(overrun_count), 2);
    L_READY = 1'b1;
    step(1);
    L_READY = 1'b0;
    check("ovr_l_accept", {30'b0, L_VALID, R_VALID}, 1);
    R_READY = 1'b1;
    step(1);
    check("ovr_r_accept", 32'(R_VALID), 0);
    L_READY = 1'b1;

    // START+STOP together, and START of an empty clip
    write_reg(3'd0, 16'h0013);
    check("ss_playing", 32'(playing), 0);
    step(3);
    check("ss_addr_hold", 32'(rom_addr), 102);
    write_reg(3'd0, 16'h0007);
    check("empty_playing", 32'(playing), 0);
    step(3);
    check("empty_addr_hold", 32'(rom_addr), 102);
    check("empty_no_valid", {30'b0, L_VALID, R_VALID}, 0);

    // Volume shift of a full-scale negative word
    write_reg(3'd1, 16'h0002);
    force_8000 = 1'b1;
    write_reg(3'd0, 16'h0001);
    step(3);
`ifdef PACMAN_AUDIO_VOLUME_EN
    check("vol_ldata", 32'(L_DATA), 32'h0000_E000);
    check("vol_rdata", 32'(R_DATA), 32'h0000_E000);
`else
    check("vol_ldata", 32'(L_DATA), 32'h0000_8000);
    check("vol_rdata", 32'(R_DATA), 32'h0000_8000);
`endif
    write_reg(3'd0, 16'h0010);
    force_8000 = 1'b0;
    step(2);

    // Asynchronous reset during FETCH
    write_reg(3'd0, 16'h0001);
    step(1);
    check("pre_rst_addr", 32'(rom_addr), 100);
    #1 reset_n = 1'b0;
    #1;
    check("arst_addr", 32'(rom_addr), 0);
    check("arst_playing", 32'(playing), 0);
    check("arst_data", {L_DATA, R_DATA}, 0);
    check("arst_overrun", 32'(overrun_count), 0);
    step(1);
    reset_n = 1'b1;
    step(4);
    check("post_rst_valid", {30'b0, L_VALID, R_VALID}, 0);
    check("post_rst_playing", 32'(playing), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
